// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC controller.
package pc_ctrl_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        TRAP   = 2'd1,
        MRET   = 2'd2,
        BRANCH = 2'd3
    } redirect_cause_t;

    typedef struct packed {
        redirect_cause_t cause;
        logic [XLEN-1:0] target;
        logic            misaligned;
    } redirect_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response handshake between fetch controller and imem.
interface pc_fetch_ctrl_if;

    logic                         imem_req_o;
    logic [pc_ctrl_pkg::XLEN-1:0] imem_addr_o;
    logic                         imem_gnt_i;
    logic                         imem_rvalid_i;
    logic [pc_ctrl_pkg::XLEN-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/pc_redirect_arb.sv
// Priority select of the next-PC redirect source: trap > mret > branch.
module pc_redirect_arb
    import pc_ctrl_pkg::*;
(
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vector_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    output redirect_t       redir_o
);

    // Highest-priority active source wins; alignment is checked on the chosen target.
    always_comb begin
        redir_o.cause      = NONE;
        redir_o.target     = '0;
        redir_o.misaligned = 1'b0;
        if (trap_i) begin
            redir_o.cause  = TRAP;
            redir_o.target = trap_vector_i;
        end else if (mret_i) begin
            redir_o.cause  = MRET;
            redir_o.target = mepc_i;
        end else if (br_taken_i) begin
            redir_o.cause  = BRANCH;
            redir_o.target = br_target_i;
        end
        if (redir_o.cause != NONE) begin
            redir_o.misaligned = is_misaligned(redir_o.target);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: PC sequencing, imem handshake, stale-response drop, IF/ID outputs.
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    br_taken_i,
    input  logic [XLEN-1:0]         br_target_i,
    input  logic                    trap_i,
    input  logic [XLEN-1:0]         trap_vector_i,
    input  logic                    mret_i,
    input  logic [XLEN-1:0]         mepc_i,
    input  logic                    halt_i,
    pc_fetch_ctrl_if.master         imem,
    output logic [XLEN-1:0]         pc_o,
    output logic                    if_valid_o,
    output logic [XLEN-1:0]         if_pc_o,
    output logic [XLEN-1:0]         if_instr_o,
    output logic                    flush_o,
    output logic                    misalign_o,
    output logic                    halted_o
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_drop;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_instr;
    logic            r_misalign;
    logic            r_halt_pend;

    fetch_state_t    w_nxt_state;
    logic [XLEN-1:0] w_nxt_pc;
    logic            w_nxt_drop;
    logic [XLEN-1:0] w_nxt_if_pc;
    logic [XLEN-1:0] w_nxt_if_instr;
    logic            w_nxt_misalign;
    logic            w_nxt_halt_pend;

    redirect_t       w_redir;
    logic            w_redir_valid;
    logic [XLEN-1:0] w_redir_pc;

    pc_redirect_arb u_arb (
        .trap_i        (trap_i),
        .trap_vector_i (trap_vector_i),
        .mret_i        (mret_i),
        .mepc_i        (mepc_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .redir_o       (w_redir)
    );

    // A redirect acts in every state but HALT; a misaligned target refetches the current PC.
    always_comb begin
        w_redir_valid = (w_redir.cause != NONE) && (r_state != HALT) && !rst;
        w_redir_pc    = w_redir.misaligned ? r_pc : w_redir.target;
    end

    // State, PC, drop flag and IF/ID capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FETCH;
            r_pc        <= RESET_VECTOR;
            r_drop      <= 1'b0;
            r_if_pc     <= '0;
            r_if_instr  <= NOP_INSTR;
            r_misalign  <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_pc        <= w_nxt_pc;
            r_drop      <= w_nxt_drop;
            r_if_pc     <= w_nxt_if_pc;
            r_if_instr  <= w_nxt_if_instr;
            r_misalign  <= w_nxt_misalign;
            r_halt_pend <= w_nxt_halt_pend;
        end
    end

    // Next-state logic: redirect beats stall and normal sequencing.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_pc        = r_pc;
        w_nxt_drop      = r_drop;
        w_nxt_if_pc     = r_if_pc;
        w_nxt_if_instr  = r_if_instr;
        w_nxt_misalign  = w_redir_valid && w_redir.misaligned;
        w_nxt_halt_pend = r_halt_pend || halt_i;

        unique case (r_state)
            FETCH: begin
                if (w_redir_valid) begin
                    w_nxt_pc = w_redir_pc;
                    if (imem.imem_gnt_i) begin
                        // Request already accepted: its response must be discarded.
                        w_nxt_drop  = 1'b1;
                        w_nxt_state = WAIT;
                    end
                end else if (imem.imem_gnt_i) begin
                    w_nxt_state = WAIT;
                end
            end
            WAIT: begin
                if (w_redir_valid) begin
                    w_nxt_pc = w_redir_pc;
                    if (imem.imem_rvalid_i) begin
                        w_nxt_drop  = 1'b0;
                        w_nxt_state = FETCH;
                    end else begin
                        w_nxt_drop  = 1'b1;
                        w_nxt_state = WAIT;
                    end
                end else if (imem.imem_rvalid_i) begin
                    if (r_drop) begin
                        w_nxt_drop  = 1'b0;
                        w_nxt_state = FETCH;
                    end else begin
                        w_nxt_if_pc    = r_pc;
                        w_nxt_if_instr = imem.imem_rdata_i;
                        w_nxt_state    = VALID;
                    end
                end
            end
            VALID: begin
                if (w_redir_valid) begin
                    w_nxt_pc    = w_redir_pc;
                    w_nxt_state = FETCH;
                end else if (!stall_i) begin
                    w_nxt_pc    = r_pc + XLEN'(4);
                    w_nxt_state = w_nxt_halt_pend ? HALT : FETCH;
                end
            end
            HALT: begin
                w_nxt_state = HALT;
            end
            default: begin
                w_nxt_state = FETCH;
            end
        endcase
    end

    // Output mapping; flush is combinational with the redirect request.
    always_comb begin
        imem.imem_req_o  = (r_state == FETCH) && !rst;
        imem.imem_addr_o = r_pc;
        pc_o             = r_pc;
        if_valid_o       = (r_state == VALID);
        if_pc_o          = r_if_pc;
        if_instr_o       = (r_state == VALID) ? r_if_instr : NOP_INSTR;
        flush_o          = w_redir_valid;
        misalign_o       = r_misalign;
        halted_o         = (r_state == HALT);
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a small imem responder.
module tb_pc_fetch_ctrl;
    import pc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, br_taken_i, trap_i, mret_i, halt_i;
    logic [31:0] br_target_i, trap_vector_i, mepc_i;
    logic [31:0] pc_o, if_pc_o, if_instr_o;
    logic        if_valid_o, flush_o, misalign_o, halted_o;

    int          n_checks = 0;
    int          n_errors = 0;

    // imem responder state
    int          lat = 0;
    logic        gnt_en = 1'b1;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_pend = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_paddr = '0;

    pc_fetch_ctrl_if imem ();

    pc_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .trap_i        (trap_i),
        .trap_vector_i (trap_vector_i),
        .mret_i        (mret_i),
        .mepc_i        (mepc_i),
        .halt_i        (halt_i),
        .imem          (imem),
        .pc_o          (pc_o),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .flush_o       (flush_o),
        .misalign_o    (misalign_o),
        .halted_o      (halted_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem.imem_gnt_i    = imem.imem_req_o & gnt_en;
    assign imem.imem_rvalid_i = m_rvalid;
    assign imem.imem_rdata_i  = m_rdata;

    // Response arrives lat+1 cycles after the grant cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_rvalid <= 1'b0;
            m_pend   <= 1'b0;
            m_cnt    <= 0;
        end else begin
            m_rvalid <= 1'b0;
            if (m_pend) begin
                if (m_cnt == 0) begin
                    m_rvalid <= 1'b1;
                    m_rdata  <= mem_word(m_paddr);
                    m_pend   <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (imem.imem_req_o && imem.imem_gnt_i) begin
                if (lat == 0) begin
                    m_rvalid <= 1'b1;
                    m_rdata  <= mem_word(imem.imem_addr_o);
                end else begin
                    m_pend  <= 1'b1;
                    m_cnt   <= lat - 1;
                    m_paddr <= imem.imem_addr_o;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall_i = 0; br_taken_i = 0; trap_i = 0; mret_i = 0; halt_i = 0;
        br_target_i = '0; trap_vector_i = '0; mepc_i = '0;
        tick; tick;

        // Reset state
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_req", 32'(imem.imem_req_o), 32'h0);
        chk("rst_valid", 32'(if_valid_o), 32'h0);
        chk("rst_if_pc", if_pc_o, 32'h0);
        chk("rst_instr", if_instr_o, NOP_INSTR);
        chk("rst_flush", 32'(flush_o), 32'h0);
        chk("rst_misalign", 32'(misalign_o), 32'h0);
        chk("rst_halted", 32'(halted_o), 32'h0);

        // Free run: FETCH, WAIT, VALID per instruction
        rst = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("run_addr", imem.imem_addr_o, 32'(4 * i));
            chk("run_req", 32'(imem.imem_req_o), 32'h1);
            chk("run_valid_f", 32'(if_valid_o), 32'h0);
            tick;
            chk("run_req_w", 32'(imem.imem_req_o), 32'h0);
            chk("run_valid_w", 32'(if_valid_o), 32'h0);
            tick;
            chk("run_valid_v", 32'(if_valid_o), 32'h1);
            chk("run_instr", if_instr_o, mem_word(32'(4 * i)));
            chk("run_if_pc", if_pc_o, 32'(4 * i));
            tick;
        end

        // Stall in VALID holds IF/ID and suppresses requests
        chk("stall_pre_addr", imem.imem_addr_o, 32'hC);
        tick; tick;
        chk("stall_valid0", 32'(if_valid_o), 32'h1);
        stall_i = 1'b1;
        repeat (4) begin
            tick;
            chk("stall_valid", 32'(if_valid_o), 32'h1);
            chk("stall_instr", if_instr_o, mem_word(32'hC));
            chk("stall_if_pc", if_pc_o, 32'hC);
            chk("stall_req", 32'(imem.imem_req_o), 32'h0);
        end
        stall_i = 1'b0;
        tick;
        chk("stall_next_req", 32'(imem.imem_req_o), 32'h1);
        chk("stall_next_addr", imem.imem_addr_o, 32'h10);

        // Branch during WAIT, coincident with rvalid: response dropped
        tick;
        br_taken_i = 1'b1; br_target_i = 32'h200; #1;
        chk("brw_flush", 32'(flush_o), 32'h1);
        tick;
        br_taken_i = 1'b0; #1;
        chk("brw_flush_off", 32'(flush_o), 32'h0);
        chk("brw_valid", 32'(if_valid_o), 32'h0);
        chk("brw_instr", if_instr_o, NOP_INSTR);
        chk("brw_addr", imem.imem_addr_o, 32'h200);
        chk("brw_req", 32'(imem.imem_req_o), 32'h1);
        tick; tick;
        chk("brw_tgt_valid", 32'(if_valid_o), 32'h1);
        chk("brw_tgt_instr", if_instr_o, mem_word(32'h200));
        chk("brw_tgt_pc", if_pc_o, 32'h200);

        // Branch during WAIT before rvalid: drop flag discards the late response
        lat = 1;
        tick;
        chk("drop_addr", imem.imem_addr_o, 32'h204);
        tick;
        chk("drop_wait_req", 32'(imem.imem_req_o), 32'h0);
        br_taken_i = 1'b1; br_target_i = 32'h300; #1;
        chk("drop_flush", 32'(flush_o), 32'h1);
        tick;
        br_taken_i = 1'b0; #1;
        chk("drop_valid", 32'(if_valid_o), 32'h0);
        chk("drop_instr", if_instr_o, NOP_INSTR);
        chk("drop_req", 32'(imem.imem_req_o), 32'h0);
        chk("drop_pc", pc_o, 32'h300);
        tick;
        chk("drop_fetch_req", 32'(imem.imem_req_o), 32'h1);
        chk("drop_fetch_addr", imem.imem_addr_o, 32'h300);
        chk("drop_fetch_valid", 32'(if_valid_o), 32'h0);
        lat = 0;
        tick; tick;
        chk("drop_tgt_valid", 32'(if_valid_o), 32'h1);
        chk("drop_tgt_instr", if_instr_o, mem_word(32'h300));

        // Priority: trap beats mret and branch
        trap_i = 1'b1; trap_vector_i = 32'h100;
        mret_i = 1'b1; mepc_i = 32'h40;
        br_taken_i = 1'b1; br_target_i = 32'h80; #1;
        chk("prio_flush", 32'(flush_o), 32'h1);
        tick;
        trap_i = 1'b0; mret_i = 1'b0; br_taken_i = 1'b0; #1;
        chk("prio_addr", imem.imem_addr_o, 32'h100);
        chk("prio_valid", 32'(if_valid_o), 32'h0);
        chk("prio_misalign", 32'(misalign_o), 32'h0);
        tick; tick;
        chk("prio_tgt_pc", if_pc_o, 32'h100);

        // Misaligned branch target rejected
        br_taken_i = 1'b1; br_target_i = 32'h82; #1;
        chk("mis_flush", 32'(flush_o), 32'h1);
        tick;
        br_taken_i = 1'b0; #1;
        chk("mis_pulse", 32'(misalign_o), 32'h1);
        chk("mis_pc", pc_o, 32'h100);
        chk("mis_valid", 32'(if_valid_o), 32'h0);
        tick;
        chk("mis_pulse_end", 32'(misalign_o), 32'h0);
        tick;
        chk("mis_refetch_pc", if_pc_o, 32'h100);

        // PC wrap at top of address space
        br_taken_i = 1'b1; br_target_i = 32'hFFFF_FFFC;
        tick;
        br_taken_i = 1'b0; #1;
        chk("wrap_addr_top", imem.imem_addr_o, 32'hFFFF_FFFC);
        tick; tick;
        chk("wrap_if_pc", if_pc_o, 32'hFFFF_FFFC);
        chk("wrap_instr", if_instr_o, mem_word(32'hFFFF_FFFC));
        tick;
        chk("wrap_addr", imem.imem_addr_o, 32'h0);
        chk("wrap_req", 32'(imem.imem_req_o), 32'h1);

        // Halt after the VALID instruction is consumed; redirects ignored
        tick; tick;
        chk("halt_pre_valid", 32'(if_valid_o), 32'h1);
        halt_i = 1'b1;
        tick;
        halt_i = 1'b0; br_taken_i = 1'b1; br_target_i = 32'h400; #1;
        chk("halt_halted", 32'(halted_o), 32'h1);
        chk("halt_req", 32'(imem.imem_req_o), 32'h0);
        chk("halt_valid", 32'(if_valid_o), 32'h0);
        chk("halt_flush", 32'(flush_o), 32'h0);
        tick;
        br_taken_i = 1'b0;
        chk("halt_stay", 32'(halted_o), 32'h1);
        chk("halt_pc", pc_o, 32'h4);
        chk("halt_req2", 32'(imem.imem_req_o), 32'h0);

        // Reset exits HALT
        rst = 1'b1;
        tick;
        chk("rst2_pc", pc_o, 32'h0);
        chk("rst2_halted", 32'(halted_o), 32'h0);
        chk("rst2_req", 32'(imem.imem_req_o), 32'h0);
        rst = 1'b0; #1;
        chk("rst2_req_after", 32'(imem.imem_req_o), 32'h1);
        chk("rst2_addr_after", imem.imem_addr_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
